// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: sits between the PC unit and decode.
// Issues fetch addresses to instruction memory under a credit limit. It pairs
// in-order memory responses with their PCs and buffers {pc, inst} for decode.
// A flush drops buffered entries and discards the responses still in flight.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   pc_valid_i/pc_addr_i/pc_ready_o      fetch address handshake from PC unit
//   flush_i                              redirect; discard all fetch state
//   imem_req_o/imem_addr_o/imem_gnt_i    memory request channel
//   imem_rvalid_i/imem_rdata_i           in-order memory response channel
//   inst_valid_o/inst_o/inst_addr_o      FIFO head towards decode
//   inst_ready_i                         decode consumes the head
module inst_fetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_addr_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PTR_W = CNT_W - 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  fetch_entry_t      fifo_q [DEPTH];
  logic [31:0]       pq_q   [DEPTH];
  logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PTR_W-1:0]  pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic              credit_c, req_c, accept_c, take_c, drop_c, pop_c;
  logic [SUM_W-1:0]  used_c;
  logic [CNT_W:0]    pending_c;

  // Request path and handshake qualifiers
  always_comb begin
    used_c   = SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q) + SUM_W'(discard_q);
    credit_c = used_c < SUM_W'(DEPTH);
    req_c    = reset_n & pc_valid_i & credit_c & ~flush_i;
    accept_c = req_c & imem_gnt_i;
    // Stray responses (none outstanding) are ignored rather than popping garbage
    drop_c   = imem_rvalid_i & (discard_q != '0);
    take_c   = imem_rvalid_i & (discard_q == '0) & (inflight_q != '0);
    pop_c    = (fifo_cnt_q != '0) & inst_ready_i & ~flush_i;
  end

  assign imem_req_o   = req_c;
  assign imem_addr_o  = pc_addr_i;
  assign pc_ready_o   = accept_c;
  assign inst_valid_o = (fifo_cnt_q != '0);
  assign inst_o       = fifo_q[fifo_rd_q].inst;
  assign inst_addr_o  = fifo_q[fifo_rd_q].pc;

  // Pointer and counter next-state
  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    pending_c  = (CNT_W+1)'(discard_q) + (CNT_W+1)'(inflight_q);
    if (flush_i) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      fifo_cnt_d = '0;
      inflight_d = '0;
      // Everything still outstanding must be swallowed, except a response
      // arriving right now, which is dropped in this cycle.
      if (imem_rvalid_i && (pending_c != '0)) begin
        pending_c = pending_c - (CNT_W+1)'(1);
      end
      discard_d = CNT_W'(pending_c);
    end else begin
      if (accept_c) pq_wr_d = pq_wr_q + PTR_W'(1);
      if (take_c) begin
        pq_rd_d   = pq_rd_q + PTR_W'(1);
        fifo_wr_d = fifo_wr_q + PTR_W'(1);
      end
      if (pop_c) fifo_rd_d = fifo_rd_q + PTR_W'(1);
      if (drop_c) discard_d = discard_q - CNT_W'(1);
      inflight_d = inflight_q + CNT_W'(accept_c) - CNT_W'(take_c);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(take_c) - CNT_W'(pop_c);
    end
  end

  // State and storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
        pq_q[i]   <= '0;
      end
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      if (accept_c) pq_q[pq_wr_q] <= pc_addr_i;
      if (take_c && !flush_i) fifo_q[fifo_wr_q] <= '{pc: pq_q[pq_rd_q], inst: imem_rdata_i};
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // A response with nothing outstanding is a memory protocol violation
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid_i |-> ((inflight_q != '0) || (discard_q != '0)));

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the PC unit.
- Accepts instruction addresses from the PC unit under a valid/ready handshake and issues them to the instruction memory port.
- Matches in-order memory responses back to their PCs and buffers {pc, instruction} pairs in a small FIFO that feeds decode.
- A flush, driven by the same jump event that redirects the PC unit, discards all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, combined capacity of in-flight requests plus buffered instructions; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and discard counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pc_valid_i  input  1  PC unit presents a valid fetch address.
- pc_addr_i  input  32  fetch address from the PC unit.
- pc_ready_o  output  1  address accepted this cycle; drives the PC unit's ready input.
- flush_i  input  1  jump/redirect; discard all fetch state.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  response data valid; responses are in order, one per granted request.
- imem_rdata_i  input  32  response instruction word.
- inst_valid_o  output  1  decode-side instruction valid.
- inst_o  output  32  instruction word at the FIFO head.
- inst_addr_o  output  32  PC of inst_o.
- inst_ready_i  input  1  decode consumes the FIFO head.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, pending-PC queue empty, in-flight count 0, discard count 0.
  - Reset output values: inst_valid_o=0, inst_o=0, inst_addr_o=0.
  - imem_req_o and pc_ready_o are combinational and evaluate low while reset holds.
  - Asserting reset mid-transfer drops everything; any response arriving after release without a matching request is ignored.
- Credit: credit = (inflight + fifo_count + pending_discard) < DEPTH.
- Request path is combinational:
  - imem_req_o = pc_valid_i & credit & ~flush_i.
  - imem_addr_o = pc_addr_i.
  - pc_ready_o = imem_req_o & imem_gnt_i.
- Accept: when imem_req_o & imem_gnt_i, push pc_addr_i into the pending-PC queue and increment inflight.
- Response handling (imem_rvalid_i), earliest the cycle after grant:
  - If discard>0: decrement discard and drop the data.
  - Otherwise: pop the pending-PC queue head, push {head, imem_rdata_i} into the FIFO, decrement inflight.
- Simultaneous accept and response in one cycle: inflight is unchanged.
- Output:
  - inst_valid_o = FIFO non-empty; inst_o and inst_addr_o come from FIFO head storage.
  - Latency: rvalid in cycle N gives inst_valid_o high in cycle N+1 at the earliest.
  - Pop when inst_valid_o & inst_ready_i. Push and pop in the same cycle are legal at any occupancy, including full.
  - inst_o and inst_addr_o must hold stable while inst_valid_o=1 and inst_ready_i=0.
- Flush (flush_i=1 in cycle N):
  - No request issued in N (pc_ready_o=0).
  - FIFO and pending-PC queue are cleared at the N edge; inst_valid_o=0 in N+1.
  - Discard count at the N edge:
    - inflight, minus 1 if imem_rvalid_i is high in N; that response is dropped.
    - If discard>0 in N, the new value is discard + inflight − (rvalid ? 1 : 0).
  - A decode pop in N is ignored.
- Overflow is impossible by construction (credit check). An rvalid with inflight=0 and discard=0 is a protocol error; it is flagged with a simulation assertion only.
- Wrap-around: FIFO and queue pointers are CNT_W−1 bits and wrap modulo DEPTH.

Test Plan:
- Reset, then pc_valid_i=1 at 0x0, 0x4, 0x8 with gnt=1 and one-cycle response latency (rdata 0x13, 0x93, 0x113), inst_ready_i=1 -> inst_valid_o/inst_addr_o show 0x0/0x13, 0x4/0x93, 0x8/0x113 on consecutive cycles, the first appearing 2 cycles after the first grant.
- inst_ready_i=0, DEPTH=4, continuous requests -> exactly 4 grants, then pc_ready_o=0 and imem_req_o=0. Raising inst_ready_i for 1 cycle -> exactly one new grant, and no data is lost.
- imem_gnt_i=0 for 3 cycles with pc_valid_i=1 at 0x20 -> pc_ready_o=0 throughout and imem_addr_o stays 0x20. Grant on cycle 4 -> a single request is recorded.
- 2 requests in flight (0x40, 0x44) plus 1 buffered (0x3C); pulse flush_i -> inst_valid_o=0 the next cycle. The responses for 0x40/0x44 are dropped. The next request at 0x100 returns with inst_addr_o=0x100.
- Flush in the same cycle as an rvalid with inflight=1 -> discard=0 afterwards, and the next response is accepted normally.
- Assert reset_n low mid-stream with a full FIFO -> inst_valid_o=0 immediately (asynchronously). After release, normal fetch from 0x0 resumes.
